iob_eth_wr_post: RTL

//  Posted-write buffer between the Ethernet MAC's IOb DMA master port and system memory.

---
 rtl/iob_eth_wr_post.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/iob_eth_wr_post.sv
// rtl/iob_eth_wr_post.sv - posted-write buffer between MAC IOb DMA master and system memory
// Writes are acknowledged on FIFO push; reads wait for every older write to drain first.
module iob_eth_wr_post #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       s_valid,
   input  logic [ADDR_W-1:0]          s_addr,
   input  logic [DATA_W-1:0]          s_wdata,
   input  logic [DATA_W/8-1:0]        s_wstrb,
   output logic [DATA_W-1:0]          s_rdata,
   output logic                       s_ready,
   output logic                       m_valid,
   output logic [ADDR_W-1:0]          m_addr,
   output logic [DATA_W-1:0]          m_wdata,
   output logic [DATA_W/8-1:0]        m_wstrb,
   input  logic [DATA_W-1:0]          m_rdata,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH+1)-1:0] wr_pend,
   output logic                       idle
);
   localparam int SW = DATA_W/8;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C  = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_RD_WAIT, S_RD_DONE} s_state_t;
   typedef enum logic [1:0] {M_IDLE, M_WR, M_RD} m_state_t;

   logic [ADDR_W-1:0] fifo_addr  [DEPTH];
   logic [DATA_W-1:0] fifo_wdata [DEPTH];
   logic [SW-1:0]     fifo_wstrb [DEPTH];

   s_state_t          s_state_q, s_state_d;
   m_state_t          m_state_q, m_state_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
   logic [CW-1:0]     pend_q, pend_d;
   logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
   logic              s_ready_q, s_ready_d;
   logic [DATA_W-1:0] s_rdata_q, s_rdata_d;
   logic              m_valid_q, m_valid_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic [SW-1:0]     m_wstrb_q, m_wstrb_d;
   logic              accept, is_wr, push, pop, m_ack, rd_req;

   always_comb begin
      accept = s_valid & ~s_ready_q & (s_state_q == S_IDLE);
      is_wr  = |s_wstrb;
      push   = accept & is_wr & (pend_q != FULL_C);
      m_ack  = m_valid_q & m_ready;
      pop    = m_ack & (m_state_q == M_WR);
      rd_req = (s_state_q == S_RD_DONE);
      rd_nxt = rd_ptr_q + 1'b1;

      s_state_d = s_state_q;
      m_state_d = m_state_q;
      wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = pop ? rd_nxt : rd_ptr_q;
      pend_d    = pend_q + CW'(push) - CW'(pop);
      rd_addr_d = rd_addr_q;
      s_ready_d = push;
      s_rdata_d = s_rdata_q;
      m_valid_d = m_valid_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      m_wstrb_d = m_wstrb_q;

      case (s_state_q)
         S_IDLE: begin
            if (accept && !is_wr) begin
               rd_addr_d = s_addr;
               s_state_d = S_RD_WAIT;
            end
         end
         S_RD_WAIT: begin
            if (pend_q == '0 && m_state_q == M_IDLE) s_state_d = S_RD_DONE;
         end
         S_RD_DONE: begin
            if (m_state_q == M_RD && m_ack) begin
               s_rdata_d = m_rdata;
               s_ready_d = 1'b1;
               s_state_d = S_IDLE;
            end
         end
         default: s_state_d = S_IDLE;
      endcase

      case (m_state_q)
         M_IDLE: begin
            if (pend_q != '0) begin
               m_state_d = M_WR;
               m_valid_d = 1'b1;
               m_addr_d  = fifo_addr[rd_ptr_q];
               m_wdata_d = fifo_wdata[rd_ptr_q];
               m_wstrb_d = fifo_wstrb[rd_ptr_q];
            end else if (rd_req) begin
               m_state_d = M_RD;
               m_valid_d = 1'b1;
               m_addr_d  = rd_addr_q;
               m_wdata_d = '0;
               m_wstrb_d = '0;
            end
         end
         M_WR: begin
            // Stream the next head without a bubble when more writes are queued.
            if (pop) begin
               if (pend_q != ONE_C) begin
                  m_addr_d  = fifo_addr[rd_nxt];
                  m_wdata_d = fifo_wdata[rd_nxt];
                  m_wstrb_d = fifo_wstrb[rd_nxt];
               end else begin
                  m_valid_d = 1'b0;
                  m_state_d = M_IDLE;
               end
            end
         end
         M_RD: begin
            if (m_ack) begin
               m_valid_d = 1'b0;
               m_state_d = M_IDLE;
            end
         end
         default: m_state_d = M_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr_q]  <= s_addr;
         fifo_wdata[wr_ptr_q] <= s_wdata;
         fifo_wstrb[wr_ptr_q] <= s_wstrb;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_state_q <= S_IDLE;
         m_state_q <= M_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         pend_q    <= '0;
         rd_addr_q <= '0;
         s_ready_q <= 1'b0;
         s_rdata_q <= '0;
         m_valid_q <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         m_wstrb_q <= '0;
      end else begin
         s_state_q <= s_state_d;
         m_state_q <= m_state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         pend_q    <= pend_d;
         rd_addr_q <= rd_addr_d;
         s_ready_q <= s_ready_d;
         s_rdata_q <= s_rdata_d;
         m_valid_q <= m_valid_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         m_wstrb_q <= m_wstrb_d;
      end
   end

   assign s_ready = s_ready_q;
   assign s_rdata = s_rdata_q;
   assign m_valid = m_valid_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign m_wstrb = m_wstrb_q;
   assign wr_pend = pend_q;
   assign idle    = (pend_q == '0) && (s_state_q == S_IDLE) && (m_state_q == M_IDLE);

endmodule
